cue_player: RTL and testbench

Parametrised audio/LED cue sequencer. It plays a multi-note ascending cue on a `success` event and a descending cue on a `fail` event, with a per-event cue length and configurable note, gap and tick timing. It sits between the game-logic answer checker and the piezo tone decoder / LED bank; `note_code` drives the tone decoder and `led` drives the LED bank.

---
 rtl/cue_player_if.sv | 25 ++
 rtl/cue_player.sv | 144 ++++++++++++++
 tb/tb_cue_player.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/cue_player_if.sv
// Event/config inputs and tone/LED/status outputs of the cue sequencer.
// The master side belongs to the game logic; the slave side to cue_player.
interface cue_player_if #(
  parameter int CODE_W = 4,
  parameter int LEN_W  = 4
);
  logic              success;
  logic              fail;
  logic              abort;
  logic [LEN_W-1:0]  cue_len;
  logic [CODE_W-1:0] note_code;
  logic [CODE_W-1:0] led;
  logic              busy;
  logic              done;

  modport master (
    output success, fail, abort, cue_len,
    input  note_code, led, busy, done
  );

  modport slave (
    input  success, fail, abort, cue_len,
    output note_code, led, busy, done
  );
endinterface

// File: rtl/cue_player.sv
// Plays an ascending (success) or descending (fail) note cue with tick-based
// note/gap timing; all outputs are registered.
//
// state | meaning
// IDLE  | silent, waiting for success/fail
// NOTE  | sounding note value for index idx_q
// GAP   | silent gap after the note at idx_q
module cue_player #(
  parameter int TICK_DIV   = 5000000,
  parameter int NOTE_TICKS = 1,
  parameter int GAP_TICKS  = 1,
  parameter int MAX_LEN    = 8,
  parameter int CODE_W     = 4,
  parameter int LEN_W      = $clog2(MAX_LEN + 1)
) (
  input  logic           clk,
  input  logic           reset,
  cue_player_if.slave    cue_if
);

  localparam int CYC_W = $clog2(TICK_DIV);
  localparam int TMAX  = (NOTE_TICKS > GAP_TICKS) ? NOTE_TICKS : GAP_TICKS;
  localparam int TCK_W = (TMAX > 1) ? $clog2(TMAX) : 1;

  typedef enum logic [1:0] {IDLE, NOTE, GAP} state_t;

  state_t            state_q;
  logic              fail_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  idx_q;
  logic [CYC_W-1:0]  cyc_q;
  logic [TCK_W-1:0]  tick_q;
  logic [CODE_W-1:0] note_q;
  logic              busy_q;
  logic              done_q;

  logic [LEN_W-1:0]  eff_len_d;
  logic [CODE_W-1:0] start_note_d;
  logic [CODE_W-1:0] next_note_d;
  logic              start_w;
  logic              tick_w;
  logic              note_end_w;
  logic              gap_end_w;
  logic              last_w;

  // success: i+1 ascending; fail: L+1-i descending
  function automatic logic [CODE_W-1:0] note_val(input logic             is_fail,
                                                 input logic [LEN_W-1:0] len,
                                                 input logic [LEN_W-1:0] idx);
    logic [CODE_W-1:0] l_c;
    logic [CODE_W-1:0] i_c;
    l_c = CODE_W'(len);
    i_c = CODE_W'(idx);
    if (is_fail) return l_c + CODE_W'(1) - i_c;
    else         return i_c + CODE_W'(1);
  endfunction

  always_comb begin
    eff_len_d = cue_if.cue_len;
    if (cue_if.cue_len == '0)
      eff_len_d = LEN_W'(1);
    else if (cue_if.cue_len > LEN_W'(MAX_LEN))
      eff_len_d = LEN_W'(MAX_LEN);
  end

  assign start_w      = (cue_if.success | cue_if.fail) & ~cue_if.abort;
  assign start_note_d = note_val(cue_if.fail, eff_len_d, '0);
  assign next_note_d  = note_val(fail_q, len_q, idx_q + LEN_W'(1));
  assign tick_w       = busy_q && (cyc_q == CYC_W'(TICK_DIV - 1));
  assign note_end_w   = tick_w && (tick_q == TCK_W'(NOTE_TICKS - 1));
  assign gap_end_w    = tick_w && (tick_q == TCK_W'(GAP_TICKS - 1));
  assign last_w       = (idx_q == len_q - LEN_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      fail_q  <= 1'b0;
      len_q   <= '0;
      idx_q   <= '0;
      cyc_q   <= '0;
      tick_q  <= '0;
      note_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (cue_if.abort) begin
        state_q <= IDLE;
        idx_q   <= '0;
        cyc_q   <= '0;
        tick_q  <= '0;
        note_q  <= '0;
        busy_q  <= 1'b0;
      end else if (start_w) begin
        // any event restarts from index 0, even mid-cue
        state_q <= NOTE;
        fail_q  <= cue_if.fail;
        len_q   <= eff_len_d;
        idx_q   <= '0;
        cyc_q   <= '0;
        tick_q  <= '0;
        note_q  <= start_note_d;
        busy_q  <= 1'b1;
      end else begin
        if (busy_q) cyc_q <= tick_w ? '0 : cyc_q + CYC_W'(1);
        case (state_q)
          NOTE: begin
            if (note_end_w) begin
              tick_q  <= '0;
              state_q <= GAP;
              note_q  <= '0;
            end else if (tick_w) begin
              tick_q <= tick_q + TCK_W'(1);
            end
          end
          GAP: begin
            if (gap_end_w) begin
              tick_q <= '0;
              if (last_w) begin
                state_q <= IDLE;
                idx_q   <= '0;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                state_q <= NOTE;
                idx_q   <= idx_q + LEN_W'(1);
                note_q  <= next_note_d;
              end
            end else if (tick_w) begin
              tick_q <= tick_q + TCK_W'(1);
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign cue_if.note_code = note_q;
  assign cue_if.led       = note_q;
  assign cue_if.busy      = busy_q;
  assign cue_if.done      = done_q;

endmodule

// File: tb/tb_cue_player.sv
// Directed bench for cue_player: table of whole cues plus hand sequences for
// restart, abort, done-cycle restart and asynchronous reset.
module tb_cue_player;
  localparam int TICK_DIV   = 4;
  localparam int NOTE_TICKS = 2;
  localparam int GAP_TICKS  = 1;
  localparam int MAX_LEN    = 8;
  localparam int CODE_W     = 4;
  localparam int LEN_W      = 4;
  localparam int NT  = NOTE_TICKS * TICK_DIV;               // 8 cycles of tone
  localparam int PER = (NOTE_TICKS + GAP_TICKS) * TICK_DIV; // 12 cycles per note

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;

  cue_player_if #(.CODE_W(CODE_W), .LEN_W(LEN_W)) cif ();

  cue_player #(
    .TICK_DIV(TICK_DIV), .NOTE_TICKS(NOTE_TICKS), .GAP_TICKS(GAP_TICKS),
    .MAX_LEN(MAX_LEN), .CODE_W(CODE_W), .LEN_W(LEN_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cue_if(cif.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit s;
    bit f;
    int len;
    int exp_first;
    bit exp_up;
    int exp_l;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // drive one event cycle; returns at the negedge after the sampling edge
  task automatic pulse(input bit s, input bit f, input bit a, input int len);
    @(negedge clk);
    cif.success = s;
    cif.fail    = f;
    cif.abort   = a;
    cif.cue_len = LEN_W'(len);
    @(negedge clk);
    cif.success = 1'b0;
    cif.fail    = 1'b0;
    cif.abort   = 1'b0;
  endtask

  task automatic run_part(input int first, input bit up, input int ncyc, input string tag);
    for (int c = 0; c < ncyc; c++) begin
      int b;
      int en;
      b  = c / PER;
      en = ((c % PER) < NT) ? (up ? first + b : first - b) : 0;
      chk($sformatf("%s note[%0d]", tag, c), int'(cif.note_code), en);
      chk($sformatf("%s led[%0d]", tag, c), int'(cif.led), en);
      chk($sformatf("%s busy[%0d]", tag, c), int'(cif.busy), 1);
      chk($sformatf("%s done[%0d]", tag, c), int'(cif.done), 0);
      @(negedge clk);
    end
  endtask

  // whole cue; returns at the negedge of the done cycle
  task automatic run_cue(input int first, input bit up, input int l, input string tag);
    run_part(first, up, l * PER, tag);
    chk({tag, " end busy"}, int'(cif.busy), 0);
    chk({tag, " end done"}, int'(cif.done), 1);
    chk({tag, " end note"}, int'(cif.note_code), 0);
  endtask

  task automatic idle_check(input int ncyc, input string tag);
    for (int c = 0; c < ncyc; c++) begin
      chk($sformatf("%s idle busy[%0d]", tag, c), int'(cif.busy), 0);
      chk($sformatf("%s idle note[%0d]", tag, c), int'(cif.note_code), 0);
      chk($sformatf("%s idle done[%0d]", tag, c), int'(cif.done), 0);
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk  = 0;
    n_fail = 0;
    vecs[0] = '{s:1, f:0, len:3,  exp_first:1, exp_up:1, exp_l:3};
    vecs[1] = '{s:0, f:1, len:3,  exp_first:4, exp_up:0, exp_l:3};
    vecs[2] = '{s:0, f:1, len:8,  exp_first:9, exp_up:0, exp_l:8};
    vecs[3] = '{s:1, f:1, len:2,  exp_first:3, exp_up:0, exp_l:2};
    vecs[4] = '{s:1, f:0, len:0,  exp_first:1, exp_up:1, exp_l:1};
    vecs[5] = '{s:1, f:0, len:12, exp_first:1, exp_up:1, exp_l:8};
    vecs[6] = '{s:0, f:1, len:0,  exp_first:2, exp_up:0, exp_l:1};
    vecs[7] = '{s:0, f:1, len:15, exp_first:9, exp_up:0, exp_l:8};

    reset       = 1'b1;
    cif.success = 1'b0;
    cif.fail    = 1'b0;
    cif.abort   = 1'b0;
    cif.cue_len = '0;
    #2;
    chk("reset note", int'(cif.note_code), 0);
    chk("reset led", int'(cif.led), 0);
    chk("reset busy", int'(cif.busy), 0);
    chk("reset done", int'(cif.done), 0);
    @(negedge clk);
    reset = 1'b0;
    idle_check(3, "post-reset");

    foreach (vecs[k]) begin
      pulse(vecs[k].s, vecs[k].f, 1'b0, vecs[k].len);
      run_cue(vecs[k].exp_first, vecs[k].exp_up, vecs[k].exp_l, $sformatf("vec%0d", k));
      @(negedge clk);
      chk($sformatf("vec%0d done one-shot", k), int'(cif.done), 0);
    end

    // new event in the done cycle starts immediately
    pulse(1'b1, 1'b0, 1'b0, 2);
    run_cue(1, 1'b1, 2, "pre-restart");
    cif.success = 1'b1;
    cif.cue_len = LEN_W'(1);
    @(negedge clk);
    cif.success = 1'b0;
    run_cue(1, 1'b1, 1, "done-cycle restart");
    @(negedge clk);

    // fail during second note of a success cue abandons it without done
    pulse(1'b1, 1'b0, 1'b0, 4);
    run_part(1, 1'b1, PER + 3, "interrupted");
    pulse(1'b0, 1'b1, 1'b0, 2);
    run_cue(3, 1'b0, 2, "restart fail");
    @(negedge clk);

    // abort inside a gap
    pulse(1'b1, 1'b0, 1'b0, 2);
    run_part(1, 1'b1, NT + 1, "pre-abort");
    pulse(1'b0, 1'b0, 1'b1, 2);
    idle_check(PER * 2, "abort gap");

    // abort wins over a simultaneous success
    pulse(1'b1, 1'b0, 1'b1, 3);
    idle_check(4, "abort+success");

    // asynchronous reset mid-note
    pulse(1'b1, 1'b0, 1'b0, 3);
    run_part(1, 1'b1, 4, "pre-reset");
    #2 reset = 1'b1;
    #1;
    chk("async reset note", int'(cif.note_code), 0);
    chk("async reset led", int'(cif.led), 0);
    chk("async reset busy", int'(cif.busy), 0);
    @(posedge clk);
    #1;
    chk("held reset busy", int'(cif.busy), 0);
    @(negedge clk);
    reset = 1'b0;
    pulse(1'b1, 1'b0, 1'b0, 3);
    run_cue(1, 1'b1, 3, "after reset");

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
